// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin two-port sequencer for a clockless 4x4 RAM (setup, enable, hold)
module ram_port_arbiter #(
  parameter int ACCESS_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       wr_a,
  input  logic       wr_b,
  input  logic [1:0] addr_a,
  input  logic [1:0] addr_b,
  input  logic [3:0] wdata_a,
  input  logic [3:0] wdata_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic [3:0] rdata_a,
  output logic [3:0] rdata_b,
  output logic       busy,
  output logic       mem_en,
  output logic       rd_wr,
  output logic [1:0] addr,
  output logic [3:0] wr_data,
  input  logic [3:0] rd_data
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;
  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n, rdata_a_n, rdata_b_n, wr_data_n;
  logic [1:0] addr_n;
  logic pri, pri_n, win, win_n;
  logic gnt_a_n, gnt_b_n, ack_a_n, ack_b_n, mem_en_n, rd_wr_n;
  // register state and every output so the RAM bus is glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pri     <= 1'b0;
      win     <= 1'b0;
      gnt_a   <= 1'b0;
      gnt_b   <= 1'b0;
      ack_a   <= 1'b0;
      ack_b   <= 1'b0;
      rdata_a <= '0;
      rdata_b <= '0;
      busy    <= 1'b0;
      mem_en  <= 1'b0;
      rd_wr   <= 1'b1;
      addr    <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pri     <= pri_n;
      win     <= win_n;
      gnt_a   <= gnt_a_n;
      gnt_b   <= gnt_b_n;
      ack_a   <= ack_a_n;
      ack_b   <= ack_b_n;
      rdata_a <= rdata_a_n;
      rdata_b <= rdata_b_n;
      busy    <= state_n != IDLE;
      mem_en  <= mem_en_n;
      rd_wr   <= rd_wr_n;
      addr    <= addr_n;
      wr_data <= wr_data_n;
    end
  end
  // arbitration and access sequencing; bus fields move only entering SETUP or leaving HOLD
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pri_n     = pri;
    win_n     = win;
    gnt_a_n   = gnt_a;
    gnt_b_n   = gnt_b;
    ack_a_n   = 1'b0;
    ack_b_n   = 1'b0;
    rdata_a_n = rdata_a;
    rdata_b_n = rdata_b;
    mem_en_n  = 1'b0;
    rd_wr_n   = rd_wr;
    addr_n    = addr;
    wr_data_n = wr_data;
    case (state)
      IDLE: if (req_a || req_b) begin
        win_n     = req_b && (!req_a || pri);
        state_n   = SETUP;
        gnt_a_n   = !win_n;
        gnt_b_n   = win_n;
        rd_wr_n   = win_n ? !wr_b : !wr_a;
        addr_n    = win_n ? addr_b : addr_a;
        wr_data_n = win_n ? wdata_b : wdata_a;
      end
      SETUP: begin
        state_n  = ACCESS;
        cnt_n    = CNT_LOAD;
        mem_en_n = 1'b1;
      end
      ACCESS: if (cnt == 4'd0) begin
        state_n   = HOLD;
        ack_a_n   = !win;
        ack_b_n   = win;
        rdata_a_n = (rd_wr && !win) ? rd_data : rdata_a;
        rdata_b_n = (rd_wr && win) ? rd_data : rdata_b;
      end else begin
        cnt_n    = cnt - 4'd1;
        mem_en_n = 1'b1;
      end
      HOLD: begin
        state_n   = IDLE;
        pri_n     = !win;
        gnt_a_n   = 1'b0;
        gnt_b_n   = 1'b0;
        rd_wr_n   = 1'b1;
        addr_n    = '0;
        wr_data_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scoreboard bench for two arbiter instances (N=1 and N=3) each driving a RAM model
module tb_ram_port_arbiter;
  typedef struct packed {
    logic       port;
    logic       wr;
    logic [1:0] addr;
    logic [3:0] data;
  } op_t;
  localparam logic [20:0] RST_SNAP = 21'b0000001_00_0000_0000_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_a [2], req_b [2], wr_a [2], wr_b [2];
  logic [1:0] addr_a [2], addr_b [2];
  logic [3:0] wdata_a [2], wdata_b [2];
  logic gnt_a [2], gnt_b [2], ack_a [2], ack_b [2], busy [2], mem_en [2], rd_wr [2];
  logic [3:0] rdata_a [2], rdata_b [2], wr_data [2], rd_data [2];
  logic [1:0] addr [2];
  op_t sb [2][$];
  op_t stim [2][2][$];
  logic [3:0] mdl [2][4];
  logic [3:0] last_rd [2][2];
  int errors = 0;
  int checks = 0;
  int rst_cnt = 0;
  int seen_rst = 0;
  logic pen [2];
  logic [6:0] pbus [2];
  int len [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [3:0] mem [4];
    ram_port_arbiter #(.ACCESS_CYCLES(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_a(req_a[g]), .req_b(req_b[g]), .wr_a(wr_a[g]), .wr_b(wr_b[g]),
      .addr_a(addr_a[g]), .addr_b(addr_b[g]), .wdata_a(wdata_a[g]), .wdata_b(wdata_b[g]),
      .gnt_a(gnt_a[g]), .gnt_b(gnt_b[g]), .ack_a(ack_a[g]), .ack_b(ack_b[g]),
      .rdata_a(rdata_a[g]), .rdata_b(rdata_b[g]), .busy(busy[g]),
      .mem_en(mem_en[g]), .rd_wr(rd_wr[g]), .addr(addr[g]), .wr_data(wr_data[g]),
      .rd_data(rd_data[g])
    );
    always @(posedge clk) if (mem_en[g] && !rd_wr[g]) mem[addr[g]] <= wr_data[g];
    assign rd_data[g] = mem[addr[g]];
  end

  always @(negedge rst_n) rst_cnt++;

  // bus stability while enabled, enable pulse width, grant exclusivity
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n && seen_rst == rst_cnt) begin
        if (mem_en[d] || pen[d]) begin
          checks++;
          if ({rd_wr[d], addr[d], wr_data[d]} !== pbus[d]) begin
            errors++;
            $display("FAIL bus_stable[%0d]: got %b prev %b", d, {rd_wr[d], addr[d], wr_data[d]}, pbus[d]);
          end
        end
        if (pen[d] && !mem_en[d]) begin
          checks++;
          if (len[d] != (d == 0 ? 1 : 3)) begin
            errors++;
            $display("FAIL mem_en_width[%0d]: got %0d exp %0d", d, len[d], d == 0 ? 1 : 3);
          end
        end
        if (gnt_a[d] || gnt_b[d]) begin
          checks++;
          if (gnt_a[d] && gnt_b[d]) begin
            errors++;
            $display("FAIL gnt_overlap[%0d]: got both grants high exp one", d);
          end
        end
      end
      len[d] = mem_en[d] ? len[d] + 1 : 0;
      pen[d] = mem_en[d];
      pbus[d] = {rd_wr[d], addr[d], wr_data[d]};
    end
    seen_rst = rst_cnt;
  end

  function automatic logic [20:0] snap(input int d);
    return {gnt_a[d], gnt_b[d], ack_a[d], ack_b[d], busy[d], mem_en[d], rd_wr[d],
            addr[d], wr_data[d], rdata_a[d], rdata_b[d]};
  endfunction

  task automatic add(input int d, input logic p, input logic w, input logic [1:0] a, input logic [3:0] v);
    op_t o;
    o.port = p;
    o.wr = w;
    o.addr = a;
    o.data = w ? v : mdl[d][a];
    if (w) mdl[d][a] = v;
    sb[d].push_back(o);
    stim[d][p].push_back(o);
  endtask

  task automatic load(input int d, input logic p);
    op_t o;
    logic has;
    has = stim[d][p].size() != 0;
    o = has ? stim[d][p].pop_front() : '0;
    if (!p) begin
      req_a[d] = has; wr_a[d] = o.wr; addr_a[d] = o.addr; wdata_a[d] = o.wr ? o.data : 4'b0;
    end else begin
      req_b[d] = has; wr_b[d] = o.wr; addr_b[d] = o.addr; wdata_b[d] = o.wr ? o.data : 4'b0;
    end
  endtask

  task automatic serve(input int d, input int n);
    int seen = 0, cyc = 0, last = 0, nn;
    logic pg = 1'b0;
    op_t e;
    nn = d == 0 ? 1 : 3;
    load(d, 1'b0);
    load(d, 1'b1);
    while (seen < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if ((gnt_a[d] || gnt_b[d]) && !pg) begin
        checks++;
        if (sb[d].size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected[%0d]: got grant exp none", d);
        end else begin
          e = sb[d][0];
          if ({gnt_b[d], gnt_a[d], rd_wr[d], addr[d], wr_data[d]} !==
              {e.port, !e.port, !e.wr, e.addr, e.wr ? e.data : 4'b0}) begin
            errors++;
            $display("FAIL grant_bus[%0d]: got gnt_b=%b rd_wr=%b addr=%b wd=%b exp port=%b rd_wr=%b addr=%b",
                     d, gnt_b[d], rd_wr[d], addr[d], wr_data[d], e.port, !e.wr, e.addr);
          end
          if (seen == 0) begin
            checks++;
            if (cyc != 1) begin
              errors++;
              $display("FAIL grant_latency[%0d]: got %0d exp 1", d, cyc);
            end
          end
        end
      end
      pg = gnt_a[d] || gnt_b[d];
      if (ack_a[d] || ack_b[d]) begin
        checks++;
        if (sb[d].size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected[%0d]: got ack exp none", d);
        end else begin
          e = sb[d].pop_front();
          if ({ack_b[d], ack_a[d]} !== (e.port ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL ack_port[%0d]: got %b exp %b", d, {ack_b[d], ack_a[d]}, e.port ? 2'b10 : 2'b01);
          end
          if (!e.wr) last_rd[d][e.port] = e.data;
          checks++;
          if ({rdata_b[d], rdata_a[d]} !== {last_rd[d][1], last_rd[d][0]}) begin
            errors++;
            $display("FAIL rdata[%0d]: got b=%b a=%b exp b=%b a=%b", d, rdata_b[d], rdata_a[d],
                     last_rd[d][1], last_rd[d][0]);
          end
          checks++;
          if (seen == 0 ? cyc != nn + 2 : cyc - last != nn + 3) begin
            errors++;
            $display("FAIL ack_timing[%0d]: got %0d exp %0d", d, seen == 0 ? cyc : cyc - last,
                     seen == 0 ? nn + 2 : nn + 3);
          end
          load(d, e.port);
        end
        last = cyc;
        seen++;
      end
    end
    if (seen < n) begin
      checks++;
      errors++;
      $display("FAIL serve_timeout[%0d]: got %0d acks exp %0d", d, seen, n);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_a[d] = 1'b0;
      req_b[d] = 1'b0;
      last_rd[d][0] = 4'b0;
      last_rd[d][1] = 4'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (snap(d) !== RST_SNAP) begin
        errors++;
        $display("FAIL reset_values[%0d]: got %b exp %b", d, snap(d), RST_SNAP);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (snap(d) !== RST_SNAP) begin
        errors++;
        $display("FAIL idle_values[%0d]: got %b exp %b", d, snap(d), RST_SNAP);
      end
    end
  endtask

  task automatic test_single_write();
    add(0, 1'b0, 1'b1, 2'b00, 4'b0001);
    add(0, 1'b0, 1'b0, 2'b00, 4'b0);
    serve(0, 2);
  endtask

  task automatic test_two_ports();
    apply_reset();
    add(0, 1'b0, 1'b1, 2'b01, 4'b0110);
    add(0, 1'b1, 1'b1, 2'b10, 4'b1110);
    add(0, 1'b0, 1'b0, 2'b01, 4'b0);
    add(0, 1'b1, 1'b0, 2'b10, 4'b0);
    add(0, 1'b0, 1'b0, 2'b00, 4'b0);
    serve(0, 5);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      add(0, 1'b0, 1'b1, 2'b00, 4'(i + 2));
      add(0, 1'b1, 1'b0, 2'b00, 4'b0);
    end
    serve(0, 8);
  endtask

  task automatic test_access_cycles3();
    add(1, 1'b1, 1'b1, 2'b11, 4'b1111);
    add(1, 1'b1, 1'b0, 2'b11, 4'b0);
    serve(1, 2);
    checks++;
    if (rdata_a[1] !== 4'b0000) begin
      errors++;
      $display("FAIL rdata_a_untouched: got %b exp 0000", rdata_a[1]);
    end
  endtask

  task automatic test_reset_mid();
    logic seen_ack = 1'b0;
    req_a[0] = 1'b1; wr_a[0] = 1'b1; addr_a[0] = 2'b10; wdata_a[0] = 4'b1010;
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (mem_en[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_access_en: got %b exp 1", mem_en[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (snap(0) !== RST_SNAP) begin
      errors++;
      $display("FAIL async_reset: got %b exp %b", snap(0), RST_SNAP);
    end
    req_a[0] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      last_rd[d][0] = 4'b0;
      last_rd[d][1] = 4'b0;
    end
    repeat (3) begin
      @(negedge clk);
      seen_ack = seen_ack | ack_a[0] | ack_b[0];
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seen_ack = seen_ack | ack_a[0] | ack_b[0];
    end
    checks++;
    if (seen_ack !== 1'b0) begin
      errors++;
      $display("FAIL no_ack_after_abort: got %b exp 0", seen_ack);
    end
    add(0, 1'b0, 1'b0, 2'b01, 4'b0);
    serve(0, 1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_a[d] = 1'b0; req_b[d] = 1'b0; wr_a[d] = 1'b0; wr_b[d] = 1'b0;
      addr_a[d] = 2'b0; addr_b[d] = 2'b0; wdata_a[d] = 4'b0; wdata_b[d] = 4'b0;
      pen[d] = 1'b0; pbus[d] = 7'b1000000; len[d] = 0;
      last_rd[d][0] = 4'b0; last_rd[d][1] = 4'b0;
      for (int a = 0; a < 4; a++) mdl[d][a] = 4'b0;
    end
    test_reset();
    test_single_write();
    test_two_ports();
    test_back_to_back();
    test_access_cycles3();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester round-robin controller for the 4x4 RAM (`four_by_four_ram`), which has no clock and is enable/level driven. The block owns the RAM control bus (`mem_en`, `rd_wr`, `addr`, `wr_data`) and sequences every access as setup, enable, then hold. This guarantees `rd_wr`, `addr` and `wr_data` only change while `mem_en` is low. Each requester gets a registered read-data return and a one-cycle completion pulse.

## Interface
- `ACCESS_CYCLES`, default 1: number of cycles `mem_en` stays high per access. Legal range is 1..15 (4-bit counter).
- `clk` input 1: clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_a`, `req_b` input 1: access request. Must be held until the matching `ack_x`.
- `wr_a`, `wr_b` input 1: 1 = write, 0 = read. Must be stable while `req_x` is high.
- `addr_a`, `addr_b` input 2: word address. Must be stable while `req_x` is high.
- `wdata_a`, `wdata_b` input 4: write data. Must be stable while `req_x` is high.
- `gnt_a`, `gnt_b` output 1: high while this port's access is in progress.
- `ack_a`, `ack_b` output 1: one-cycle completion pulse.
- `rdata_a`, `rdata_b` output 4: last data read by this port.
- `busy` output 1: high whenever state is not IDLE.
- `mem_en` output 1: RAM enable.
- `rd_wr` output 1: RAM direction; 1 = read, 0 = write.
- `addr` output 2: RAM address.
- `wr_data` output 4: RAM write data.
- `rd_data` input 4: RAM read data.

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD. State, counter and all outputs are registered.
- **IDLE**
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, that port wins.
  - If both are high, the port named by priority pointer `pri` wins. `pri` = 0 means A, 1 means B.
  - On a win: latch the winner's `wr`, `addr` and `wdata` onto the RAM bus, set `rd_wr = ~wr`, keep `mem_en` at 0, set `gnt_x` = 1, and go to SETUP.
- **SETUP** (1 cycle): bus stable, `mem_en` = 0. Load counter with `ACCESS_CYCLES-1`, then go to ACCESS.
- **ACCESS**
  - `mem_en` = 1 and the counter decrements each cycle.
  - On the cycle the counter is 0, go to HOLD. For a read, also capture `rd_data` into the winner's `rdata_x` on that same edge.
- **HOLD** (1 cycle)
  - `mem_en` = 0, bus still held, `ack_x` = 1.
  - Toggle `pri` to point at the non-winner.
  - Go to IDLE. On that edge, clear `gnt_x` and `ack_x` and return the bus to idle values.
- Idle bus values: `mem_en` 0, `rd_wr` 1, `addr` 00, `wr_data` 0000.
- Writes never modify `rdata_x`. A port's `rdata_x` is never modified by the other port's accesses.
- `rd_wr`, `addr` and `wr_data` change only on the IDLE->SETUP and HOLD->IDLE edges, so always with `mem_en` low.
- Requests are sampled only in IDLE. A request raised during another port's access waits.

## Timing
- Reset values:
  - `gnt_a`/`gnt_b` 0, `ack_a`/`ack_b` 0, `busy` 0.
  - `rdata_a`/`rdata_b` 0000.
  - `mem_en` 0, `rd_wr` 1, `addr` 00, `wr_data` 0000.
  - `pri` 0, state IDLE.
- Cycle numbering: the request is sampled at edge E0.
  - Cycle 1 (after E0): SETUP.
  - Cycles 2..1+N: ACCESS, where N = `ACCESS_CYCLES`.
  - Cycle 2+N: HOLD, with `ack` high.
  - Cycle 3+N: IDLE.
- The requester drops `req` on the edge ending HOLD. If `req` is still high in IDLE, it is taken as a new request.
- Throughput with a single active requester: one access per N+3 cycles.
- With both requests held continuously, grants alternate A, B, A, ...
- Reset asserted mid-operation:
  - All outputs and state go to their reset values immediately (asynchronous), and `mem_en` falls at once.
  - No `ack` is produced.
  - The contents of the target word after an aborted write are unspecified. Other words are unaffected.
- Deassertion of `rst_n` is synchronised by the system; the block treats it as clean.

## Test plan
- Reset, then A writes 0001 to address 00 (N=1).
  - `gnt_a` rises 1 cycle after sampling.
  - `mem_en` is high for exactly 1 cycle, with `rd_wr` = 0 and `addr` = 00 stable from SETUP through HOLD.
  - `ack_a` pulses in cycle 3. Then A reads 00: `rdata_a` = 0001 when `ack_a` is high.
- A writes 0110 to 01 and B writes 1110 to 10, both raised on the same edge after reset.
  - A is served first, then B. Read-back gives 01 = 0110 and 10 = 1110.
  - Read-back of 00 still gives 0001.
- Both requests held high for 4 accesses each.
  - Grant order is A, B, A, B, ...
  - No `gnt_a`/`gnt_b` overlap; each access takes N+3 cycles.
- `ACCESS_CYCLES` = 3: B writes 1111 to 11, then B reads 11.
  - `mem_en` is high for exactly 3 cycles per access.
  - `ack_b` arrives in cycle 5 (N+2); `rdata_b` = 1111 and `rdata_a` is unchanged.
- `rst_n` pulsed low during ACCESS of an A write to 10.
  - `mem_en` drops in the same cycle; all outputs return to reset values.
  - No `ack_a`. A subsequent read of 01 returns its prior value.
- Throughout every scenario, a bench monitor checks that `rd_wr`, `addr` and `wr_data` never change while `mem_en` = 1.
